// File: rtl/board_scan_draw.sv
// Clears the VGA framebuffer or scans the game board, plotting each cell as a square.
// Define BOARD_GRID_EN to draw the last row/column of every cell in GRID_COLOUR.
module board_scan_draw #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         BOARD_COLS  = 10,
    parameter int         BOARD_ROWS  = 20,
    parameter int         CELL_PX     = 6,
    parameter int         ORIGIN_X    = 3,
    parameter int         ORIGIN_Y    = 0,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] GRID_COLOUR = 3'b111
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          clear_req,
    input  logic                          draw_req,
    output logic [$clog2(BOARD_COLS)-1:0] cell_col,
    output logic [$clog2(BOARD_ROWS)-1:0] cell_row,
    input  logic [2:0]                    cell_colour,
    output logic [7:0]                    vga_x,
    output logic [6:0]                    vga_y,
    output logic [2:0]                    vga_colour,
    output logic                          vga_plot,
    output logic                          busy,
    output logic                          done
);

    localparam int CW = $clog2(BOARD_COLS);
    localparam int RW = $clog2(BOARD_ROWS);

    localparam logic [8:0]    X_LAST   = 9'(SCREEN_W - 1);
    localparam logic [8:0]    Y_LAST   = 9'(SCREEN_H - 1);
    localparam logic [8:0]    P_LAST   = 9'(CELL_PX - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(BOARD_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(BOARD_ROWS - 1);

    if ((ORIGIN_X + BOARD_COLS * CELL_PX > SCREEN_W) ||
        (ORIGIN_Y + BOARD_ROWS * CELL_PX > SCREEN_H)) begin : g_bad_geom
        $error("board_scan_draw: board does not fit on the screen");
    end

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH0,
        FETCH1,
        DRAW,
        FIN
    } state_t;

    state_t        state, state_n;
    logic [8:0]    x, x_n, y, y_n;
    logic [8:0]    px, px_n, py, py_n;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    logic [2:0]    cell_q, cell_q_n;

    logic [7:0] vga_x_n;
    logic [6:0] vga_y_n;
    logic [2:0] colour_n;
    logic       plot_n, busy_n, done_n, grid_px;

    assign cell_col = col;
    assign cell_row = row;

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        px_n     = px;
        py_n     = py;
        col_n    = col;
        row_n    = row;
        cell_q_n = cell_q;

        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    x_n     = '0;
                    y_n     = '0;
                end else if (draw_req) begin
                    state_n = FETCH0;
                    col_n   = '0;
                    row_n   = '0;
                end
            end
            CLEAR: begin
                if (x == X_LAST) begin
                    x_n = '0;
                    if (y == Y_LAST) state_n = FIN;
                    else             y_n     = y + 9'd1;
                end else begin
                    x_n = x + 9'd1;
                end
            end
            FETCH0: state_n = FETCH1;
            FETCH1: begin
                state_n  = DRAW;
                px_n     = '0;
                py_n     = '0;
                cell_q_n = cell_colour;
            end
            DRAW: begin
                if (px == P_LAST) begin
                    px_n = '0;
                    if (py == P_LAST) begin
                        py_n    = '0;
                        state_n = FETCH0;
                        if (col == COL_LAST) begin
                            col_n = '0;
                            if (row == ROW_LAST) begin
                                col_n   = col;
                                state_n = FIN;
                            end else begin
                                row_n = row + RW'(1);
                            end
                        end else begin
                            col_n = col + CW'(1);
                        end
                    end else begin
                        py_n = py + 9'd1;
                    end
                end else begin
                    px_n = px + 9'd1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state.
        vga_x_n  = vga_x;
        vga_y_n  = vga_y;
        colour_n = vga_colour;
        plot_n   = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
`ifdef BOARD_GRID_EN
        grid_px  = (px_n == P_LAST) || (py_n == P_LAST);
`else
        grid_px  = 1'b0;
`endif

        unique case (state_n)
            CLEAR: begin
                vga_x_n  = 8'(x_n);
                vga_y_n  = 7'(y_n);
                colour_n = BG_COLOUR;
                plot_n   = 1'b1;
                busy_n   = 1'b1;
            end
            DRAW: begin
                vga_x_n  = 8'(9'(ORIGIN_X) + 9'(col_n) * 9'(CELL_PX) + px_n);
                vga_y_n  = 7'(9'(ORIGIN_Y) + 9'(row_n) * 9'(CELL_PX) + py_n);
                colour_n = grid_px ? GRID_COLOUR : cell_q_n;
                plot_n   = 1'b1;
                busy_n   = 1'b1;
            end
            FETCH0, FETCH1: busy_n = 1'b1;
            FIN:            done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            px         <= '0;
            py         <= '0;
            col        <= '0;
            row        <= '0;
            cell_q     <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            px         <= px_n;
            py         <= py_n;
            col        <= col_n;
            row        <= row_n;
            cell_q     <= cell_q_n;
            vga_x      <= vga_x_n;
            vga_y      <= vga_y_n;
            vga_colour <= colour_n;
            vga_plot   <= plot_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_board_scan_draw.sv
// Scoreboard bench for board_scan_draw: expected plots and op lengths are queued
// by the stimulus, a negedge monitor pops and compares them.
module tb_board_scan_draw;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       draw_req = 1'b0;
    logic [3:0] cell_col;
    logic [4:0] cell_row;
    logic [2:0] cell_colour = 3'b000;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    logic [2:0] board [10][20];
    logic [2:0] fb [160][120];

    plot_t exp_q[$];
    int    exp_busy_q[$];

    int assert_cnt = 0;
    int fail_cnt = 0;
    int done_cnt = 0;
    int plot_cnt = 0;
    int busy_cnt = 0;
    logic prev_plot = 1'b0;

    always #10 clk = ~clk;

    board_scan_draw dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .clear_req  (clear_req),
        .draw_req   (draw_req),
        .cell_col   (cell_col),
        .cell_row   (cell_row),
        .cell_colour(cell_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    // Board storage with one-cycle synchronous read.
    always @(posedge clk) cell_colour <= board[cell_col][cell_row];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_clear();
        plot_t e;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++) begin
                e.x = 8'(xx);
                e.y = 7'(yy);
                e.c = 3'b000;
                exp_q.push_back(e);
            end
        exp_busy_q.push_back(19200);
    endtask

    task automatic push_draw();
        plot_t e;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                for (int py = 0; py < 6; py++)
                    for (int px = 0; px < 6; px++) begin
                        e.x = 8'(3 + c * 6 + px);
                        e.y = 7'(r * 6 + py);
                        e.c = board[c][r];
`ifdef BOARD_GRID_EN
                        if (px == 5 || py == 5) e.c = 3'b111;
`endif
                        exp_q.push_back(e);
                    end
        exp_busy_q.push_back(7600);
    endtask

    task automatic pulse(input logic clr, input logic drw);
        @(posedge clk);
        #1;
        clear_req = clr;
        draw_req  = drw;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        draw_req  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int start;
        int i;
        start = done_cnt;
        i = 0;
        while (done_cnt == start && i < budget) begin
            @(posedge clk);
            i++;
        end
        check(name, 32'(done_cnt != start), 1);
    endtask

    initial begin : monitor
        plot_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                prev_plot = 1'b0;
            end else begin
                if (vga_plot) begin
                    plot_cnt++;
                    fb[vga_x][vga_y] = vga_colour;
                    check("plot_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("plot_xyc", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, e});
                    end
                end
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    check("done_after_last_plot", 32'(prev_plot), 1);
                    check("plots_drained", exp_q.size(), 0);
                    check("done_busy_low", 32'(busy), 0);
                    check("done_expected", 32'(exp_busy_q.size() != 0), 1);
                    if (exp_busy_q.size() != 0)
                        check("busy_cycles", busy_cnt, exp_busy_q.pop_front());
                    busy_cnt = 0;
                end
                prev_plot = vga_plot;
            end
        end
    end

    initial begin : stimulus
        int d0;
        int p0;
        int ones;
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++) board[c][r] = 3'b000;

        #25;
        check("rst_vga_x", 32'(vga_x), 0);
        check("rst_vga_y", 32'(vga_y), 0);
        check("rst_colour", 32'(vga_colour), 0);
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_col", 32'(cell_col), 0);
        check("rst_row", 32'(cell_row), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of a draw aborts without a done pulse.
        d0 = done_cnt;
        push_draw();
        pulse(1'b0, 1'b1);
        repeat (500) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_plot", 32'(vga_plot), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        exp_q.delete();
        exp_busy_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        check("abort_no_done", done_cnt, d0);

        push_draw();
        pulse(1'b0, 1'b1);
        wait_done(8000, "draw_after_abort");

        // Full clear.
        p0 = plot_cnt;
        push_clear();
        pulse(1'b1, 1'b0);
        wait_done(20000, "clear_done");
        check("clear_plots", plot_cnt - p0, 19200);

        // Single lit cell (0,1).
        board[0][1] = 3'b001;
        p0 = plot_cnt;
        push_draw();
        pulse(1'b0, 1'b1);
        wait_done(8000, "cell01_done");
        check("cell01_plots", plot_cnt - p0, 7200);
        ones = 0;
        for (int xx = 0; xx < 160; xx++)
            for (int yy = 0; yy < 120; yy++)
                if (fb[xx][yy] == 3'b001) ones++;
`ifdef BOARD_GRID_EN
        check("cell01_count", ones, 25);
`else
        check("cell01_count", ones, 36);
`endif
        check("cell01_tl", 32'(fb[3][6]), 1);
        check("cell01_out_r", 32'(fb[9][6]), 0);
        check("cell01_out_d", 32'(fb[3][12]), 0);

        // Simultaneous requests: clear wins, draw is dropped.
        d0 = done_cnt;
        push_clear();
        pulse(1'b1, 1'b1);
        wait_done(20000, "both_done");
        repeat (50) @(posedge clk);
        check("both_one_done", done_cnt - d0, 1);
        check("both_idle", 32'(busy), 0);

        // Requests while busy are ignored.
        board[9][19] = 3'b100;
        d0 = done_cnt;
        p0 = plot_cnt;
        push_draw();
        pulse(1'b0, 1'b1);
        repeat (3) begin
            repeat (1500) @(posedge clk);
            #1 draw_req = 1'b1;
            @(posedge clk);
            #1 draw_req = 1'b0;
        end
        wait_done(8000, "busy_req_done");
        repeat (50) @(posedge clk);
        check("busy_req_one_done", done_cnt - d0, 1);
        check("busy_req_plots", plot_cnt - p0, 7200);
        check("px_57_114", 32'(fb[57][114]), 4);
`ifdef BOARD_GRID_EN
        check("px_62_114", 32'(fb[62][114]), 7);
        check("px_57_119", 32'(fb[57][119]), 7);
        check("px_8_6", 32'(fb[8][6]), 7);
`else
        check("px_62_114", 32'(fb[62][114]), 4);
        check("px_57_119", 32'(fb[57][119]), 4);
        check("px_8_6", 32'(fb[8][6]), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/board_scan_draw.md
Name: board_scan_draw

Overview:
- Parametrised VGA board renderer: clears the framebuffer, or scans a BOARD_COLS x BOARD_ROWS cell array and plots each cell as a CELL_PX x CELL_PX square.
- Sits between the game board storage (read port) and the VGA adapter plot interface (x, y, colour, plot).
- Replaces the fixed 160x120 clear and fixed 10x20 scan-draw sequencing in the top level with one generic block.

Parameters:
- SCREEN_W, 160, framebuffer width in pixels
- SCREEN_H, 120, framebuffer height in pixels
- BOARD_COLS, 10, board width in cells
- BOARD_ROWS, 20, board height in cells
- CELL_PX, 6, cell edge length in pixels
- ORIGIN_X, 3, screen x of the top-left pixel of cell (0,0)
- ORIGIN_Y, 0, screen y of the top-left pixel of cell (0,0)
- BG_COLOUR, 3'b000, colour written during clear
- GRID_COLOUR, 3'b111, grid-line colour (used only with BOARD_GRID_EN)

Ports:
- CLOCK_50 input 1: system clock, rising edge.
- reset input 1: asynchronous, active-high.
- clear_req input 1: start full-screen clear, sampled in IDLE.
- draw_req input 1: start board scan-draw, sampled in IDLE.
- cell_col output clog2(BOARD_COLS): board read column address.
- cell_row output clog2(BOARD_ROWS): board read row address.
- cell_colour input 3: board colour at (cell_col, cell_row), 0 = empty.
- vga_x output 8: plot x.
- vga_y output 7: plot y.
- vga_colour output 3: plot colour.
- vga_plot output 1: plot strobe.
- busy output 1: operation in progress.
- done output 1: one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs 0: vga_x, vga_y, vga_colour, vga_plot, cell_col, cell_row, busy, done.
- Every output is driven from a register.
- States: IDLE, CLEAR, FETCH0, FETCH1, DRAW, FIN.
- IDLE: clear_req=1 -> CLEAR with x=y=0. Otherwise draw_req=1 -> FETCH0 with col=row=0.
  - If both requests are high, clear wins and draw_req is dropped.
  - Requests are never queued; while busy=1 they are ignored.
- CLEAR: each cycle plots (x,y) with BG_COLOUR and vga_plot=1.
  - x is the inner loop (0..SCREEN_W-1), y the outer loop (0..SCREEN_H-1).
  - After (SCREEN_W-1, SCREEN_H-1) -> FIN.
  - Exactly SCREEN_W*SCREEN_H plot cycles (19200 at defaults).
- FETCH0: cell_col/cell_row hold the current cell; vga_plot=0. The board has a 1-cycle synchronous read latency.
- FETCH1: vga_plot=0; cell_colour is latched at the end of this cycle.
- DRAW: plots CELL_PX*CELL_PX pixels with the latched colour.
  - px is the inner loop, py the outer loop.
  - vga_x = ORIGIN_X + col*CELL_PX + px; vga_y = ORIGIN_Y + row*CELL_PX + py.
  - After the last pixel, advance col (inner) then row (outer) and return to FETCH0.
  - After cell (BOARD_COLS-1, BOARD_ROWS-1) -> FIN.
- Cost per cell: 2 + CELL_PX^2 cycles (38 at defaults). Full draw: 7600 cycles, 7200 of them plot cycles.
- cell_col/cell_row stay stable from FETCH0 through the end of that cell's DRAW.
- FIN: done=1 and busy=0 for one cycle, vga_plot=0, then IDLE.
- busy=1 in CLEAR, FETCH0, FETCH1 and DRAW.
- Coordinate math is computed at 9 bits and truncated to the port width.
- Elaboration-time check: ORIGIN_X + BOARD_COLS*CELL_PX <= SCREEN_W and ORIGIN_Y + BOARD_ROWS*CELL_PX <= SCREEN_H, otherwise $error.
- Reset mid-operation: immediate abort to IDLE. No done pulse; the partial frame is left as is.
- Empty cells (colour 0) are still drawn, so stale pixels are overwritten.

Optional Feature:
- Macro: BOARD_GRID_EN.
- Defined: in DRAW, pixels with px==CELL_PX-1 or py==CELL_PX-1 are plotted with GRID_COLOUR. All other pixels use the cell colour. Cycle count is unchanged.
- Undefined: every cell pixel uses the latched cell colour; GRID_COLOUR is unused.

Test Plan:
1. Assert reset during a draw (cycle 500) -> vga_plot=0 and busy=0 immediately; done never pulses. A new draw_req afterwards runs the full 7600 cycles.
2. Pulse clear_req -> busy high for 19200 cycles. Exactly 19200 plots with colour 0; first plot is (0,0), last is (159,119). done pulses once, in the cycle after the last plot.
3. Board with only cell (0,1)=3'b001 set, pulse draw_req -> 36 plots with colour 1 covering x 3..8, y 6..11. All other 7164 plots are colour 0. done pulses at cycle 7600.
4. clear_req and draw_req in the same cycle -> clear runs (19200 plots); no draw follows.
5. draw_req pulsed repeatedly while busy -> ignored. Exactly one done pulse, and 7200 plots in total.
6. With BOARD_GRID_EN and cell (9,19)=3'b100 -> pixels at x=62 (cell column 9, px=5) and y=119 plotted with 3'b111. The pixel at (57,114) is plotted with 3'b100.
